// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port RAM between instruction fetch (IF) and load/store (LS).
// Define ARB_RR_EN to settle contested cycles round-robin instead of fixed LS priority.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_done,
   output logic [DATA_W-1:0] ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StAcc, StResp} state_t;

   state_t state_q;
   logic   owner_q;  // 1 = LS owns the current access
   logic   pick_ls;

`ifdef ARB_RR_EN
   logic last_ls_q;  // 1 = LS was served most recently

   always_comb begin
      pick_ls = ls_req && (!if_req || !last_ls_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_ls_q <= 1'b0;
      end else if (state_q == StIdle && (if_req || ls_req)) begin
         last_ls_q <= pick_ls;
      end
   end
`else
   always_comb begin
      pick_ls = ls_req;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (if_req || ls_req) begin
                  owner_q   <= pick_ls;
                  mem_addr  <= pick_ls ? ls_addr : if_addr;
                  mem_wdata <= pick_ls ? ls_wdata : '0;
                  mem_we    <= pick_ls && ls_we;
                  state_q   <= StAcc;
               end else begin
                  mem_we <= 1'b0;
               end
            end
            StAcc: begin
               mem_we  <= 1'b0;
               state_q <= StResp;
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               mem_we  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign if_gnt    = (state_q == StAcc) && !owner_q;
   assign ls_gnt    = (state_q == StAcc) && owner_q;
   assign if_rvalid = (state_q == StResp) && !owner_q;
   assign ls_done   = (state_q == StResp) && owner_q;
   assign if_rdata  = mem_rdata;
   assign ls_rdata  = mem_rdata;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model with its own
// shadow memory, plus a behavioural synchronous RAM attached to the mem_* port.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [15:0] if_addr, if_rdata;
   logic        ls_req, ls_we, ls_gnt, ls_done;
   logic [15:0] ls_addr, ls_wdata, ls_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return (a * 16'd37) ^ 16'hC3C3;
   endfunction

   // Environment RAM: unwritten words read as init_val
   logic [15:0] ram    [65536];
   bit          ram_wr [65536];
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr]    <= mem_wdata;
         ram_wr[mem_addr] <= 1'b1;
      end
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: one transaction record, aged by whole cycles since acceptance
   logic [15:0] sh     [65536];
   bit          sh_v   [65536];
   bit          m_act, m_ls, m_we, m_last_ls;
   int          m_age;
   logic [15:0] m_addr, m_wdata, m_rd;

   function automatic logic [15:0] sh_rd(input logic [15:0] a);
      return sh_v[a] ? sh[a] : init_val(a);
   endfunction

   task automatic check_cycle();
      bit g, d;
      g = m_act && m_age == 1;
      d = m_act && m_age == 2;
      check_eq("busy", 32'(busy), 32'(m_act));
      check_eq("if_gnt", 32'(if_gnt), 32'(g && !m_ls));
      check_eq("ls_gnt", 32'(ls_gnt), 32'(g && m_ls));
      check_eq("if_rvalid", 32'(if_rvalid), 32'(d && !m_ls));
      check_eq("ls_done", 32'(ls_done), 32'(d && m_ls));
      check_eq("mem_we", 32'(mem_we), 32'(g && m_we));
      if (g) check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (g && m_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      if (d && !m_ls) check_eq("if_rdata", 32'(if_rdata), 32'(m_rd));
      if (d && m_ls && !m_we) check_eq("ls_rdata", 32'(ls_rdata), 32'(m_rd));
   endtask

   // Advance the model across the coming rising edge using the inputs now driven
   task automatic model_edge();
      bit w;
      if (m_act) begin
         m_age++;
         if (m_age == 3) m_act = 1'b0;
      end else if (if_req || ls_req) begin
`ifdef ARB_RR_EN
         w = ls_req && (!if_req || !m_last_ls);
`else
         w = ls_req;
`endif
         m_act     = 1'b1;
         m_age     = 1;
         m_ls      = w;
         m_we      = w && ls_we;
         m_addr    = w ? ls_addr : if_addr;
         m_wdata   = ls_wdata;
         m_last_ls = w;
         if (m_we) begin
            sh[m_addr]   = m_wdata;
            sh_v[m_addr] = 1'b1;
         end else begin
            m_rd = sh_rd(m_addr);
         end
      end
   endtask

   task automatic drive(input int pct);
      if (m_act && m_age == 1 && !m_ls) if_req = 1'b0;
      if (m_act && m_age == 1 && m_ls) ls_req = 1'b0;
      if (!if_req) begin
         if_addr = 16'($urandom_range(0, 31));
         if ($urandom_range(0, 99) < pct) if_req = 1'b1;
      end
      if (!ls_req) begin
         ls_addr  = 16'($urandom_range(0, 31));
         ls_we    = 1'($urandom_range(0, 1));
         ls_wdata = 16'($urandom);
         if ($urandom_range(0, 99) < pct) ls_req = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check_eq("rst_gnts", 32'({if_gnt, ls_gnt, if_rvalid, ls_done}), 32'd0);
      rst = 1'b0;

      // Store to 0x0040 interrupted by reset while in the grant cycle
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0040; ls_wdata = 16'hBEEF;
      @(negedge clk);
      check_eq("abort_ls_gnt", 32'(ls_gnt), 32'd1);
      check_eq("abort_mem_we", 32'(mem_we), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_eq("abort_mem_we_rst", 32'(mem_we), 32'd0);
      check_eq("abort_busy_rst", 32'(busy), 32'd0);
      check_eq("abort_ls_gnt_rst", 32'(ls_gnt), 32'd0);
      ls_req = 1'b0; ls_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("abort_no_done", 32'(ls_done), 32'd0);
         @(negedge clk);
      end
      check_eq("abort_ram_0040", 32'(ram_wr[16'h0040] ? ram[16'h0040] : init_val(16'h0040)),
               32'(init_val(16'h0040)));

      m_act = 1'b0; m_age = 0; m_ls = 1'b0; m_we = 1'b0; m_last_ls = 1'b0;
      m_addr = '0; m_wdata = '0; m_rd = '0;
      model_edge();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         check_cycle();
         drive(cyc < 60 ? 100 : (cyc < 800 ? 40 : 80));
         model_edge();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
